// File: rtl/flux_rr_scheduler.sv
// rtl/flux_rr_scheduler.sv - round-robin burst scheduler sharing one actor among FLUX fluxes (option: FLUX_FIXED_PRIO_EN)
//
// FLUX_FIXED_PRIO_EN defined  : fixed priority, lowest index wins, no burst limit.
// FLUX_FIXED_PRIO_EN undefined: round-robin with a MAX_BURST firing limit per grant.
module flux_rr_scheduler #(
  parameter int FLUX      = 2,
  parameter int TAG_WIDTH = $clog2(FLUX),
  parameter int MAX_BURST = 4,
  parameter int CNT_WIDTH = $clog2(MAX_BURST + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [FLUX-1:0]      opa_empty,
  input  logic [FLUX-1:0]      opb_empty,
  input  logic [FLUX-1:0]      res_full,
  output logic [FLUX-1:0]      read_a,
  output logic [FLUX-1:0]      read_b,
  output logic                 write,
  output logic [TAG_WIDTH-1:0] grant_tag,
  output logic                 busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t               state;
  logic [FLUX-1:0]      ready;
  logic                 grant_ready;
  logic                 fire;
  logic                 any_ready;
  logic [TAG_WIDTH-1:0] scan_idx;

`ifndef FLUX_FIXED_PRIO_EN
  logic [TAG_WIDTH-1:0] rr_ptr;
  logic [CNT_WIDTH-1:0] burst_cnt;
  logic [TAG_WIDTH-1:0] next_tag;
  logic                 burst_last;
`endif

  // A flux may fire only with both operands present and room for the result
  assign ready = ~opa_empty & ~opb_empty & ~res_full;

  // Readiness of the currently granted flux, selected without a variable index
  always_comb begin
    grant_ready = 1'b0;
    for (int i = 0; i < FLUX; i++) begin
      if (grant_tag == TAG_WIDTH'(i)) begin
        grant_ready = ready[i];
      end
    end
  end

  // Firing is purely combinational so strobes vanish the moment state leaves SERVE
  assign fire  = (state == SERVE) && enable && grant_ready;
  assign write = fire;
  assign busy  = (state == SERVE);

  // One-hot read strobes for the granted flux; both operand banks pop together
  always_comb begin
    read_a = '0;
    for (int i = 0; i < FLUX; i++) begin
      read_a[i] = fire && (grant_tag == TAG_WIDTH'(i));
    end
  end

  assign read_b = read_a;

  // Pick the first ready flux; round-robin scans from rr_ptr upward, then wraps to 0
  always_comb begin
    any_ready = 1'b0;
    scan_idx  = '0;
`ifndef FLUX_FIXED_PRIO_EN
    for (int i = 0; i < FLUX; i++) begin
      if (!any_ready && ready[i] && (TAG_WIDTH'(i) >= rr_ptr)) begin
        any_ready = 1'b1;
        scan_idx  = TAG_WIDTH'(i);
      end
    end
`endif
    for (int i = 0; i < FLUX; i++) begin
      if (!any_ready && ready[i]) begin
        any_ready = 1'b1;
        scan_idx  = TAG_WIDTH'(i);
      end
    end
  end

`ifndef FLUX_FIXED_PRIO_EN
  // Rotation target after a grant ends; explicit wrap keeps non-power-of-2 FLUX in range
  assign next_tag   = (grant_tag == TAG_WIDTH'(FLUX - 1)) ? '0 : grant_tag + 1'b1;
  assign burst_last = (burst_cnt == CNT_WIDTH'(MAX_BURST - 1));

  // Grant FSM: lock onto one flux for up to MAX_BURST firings, then rotate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_tag <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && any_ready) begin
            grant_tag <= scan_idx;
            burst_cnt <= '0;
            state     <= SERVE;
          end
        end
        SERVE: begin
          if (fire && !burst_last) begin
            burst_cnt <= burst_cnt + 1'b1;
          end else begin
            rr_ptr    <= next_tag;
            burst_cnt <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
`else
  // Grant FSM: lowest ready index wins and holds the actor until it stops firing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_tag <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && any_ready) begin
            grant_tag <= scan_idx;
            state     <= SERVE;
          end
        end
        SERVE: begin
          if (!fire) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_flux_rr_scheduler.sv
// tb/tb_flux_rr_scheduler.sv - directed self-checking bench for flux_rr_scheduler (FLUX=2 and FLUX=3)
module tb_flux_rr_scheduler;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [1:0] opa_empty, opb_empty, res_full;
  logic [1:0] read_a, read_b;
  logic       write;
  logic [0:0] grant_tag;
  logic       busy;

  logic [2:0] opa_empty3, opb_empty3, res_full3;
  logic [2:0] read_a3, read_b3;
  logic       write3;
  logic [1:0] grant_tag3;
  logic       busy3;

  int errors = 0;
  int checks = 0;

  flux_rr_scheduler #(.FLUX(2), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .opa_empty(opa_empty), .opb_empty(opb_empty), .res_full(res_full),
    .read_a(read_a), .read_b(read_b), .write(write),
    .grant_tag(grant_tag), .busy(busy)
  );

  flux_rr_scheduler #(.FLUX(3), .MAX_BURST(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .opa_empty(opa_empty3), .opb_empty(opb_empty3), .res_full(res_full3),
    .read_a(read_a3), .read_b(read_b3), .write(write3),
    .grant_tag(grant_tag3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int exp_w1 [10];
  int exp_w2 [12];
  int exp_t2 [12];
  int exp_w3 [6];
  int exp_tag_alt;
  int wr_cnt;

  initial begin
`ifdef FLUX_FIXED_PRIO_EN
    exp_w1 = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    exp_w2 = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    exp_t2 = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_w3 = '{0, 1, 1, 0, 0, 1};
    exp_tag_alt = 0;
`else
    exp_w1 = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1};
    exp_w2 = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};
    exp_t2 = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    exp_w3 = '{0, 1, 1, 0, 1, 1};
    exp_tag_alt = 1;
`endif

    rst_n      = 1'b0;
    enable     = 1'b1;
    opa_empty  = 2'b11;
    opb_empty  = 2'b11;
    res_full   = 2'b00;
    opa_empty3 = 3'b111;
    opb_empty3 = 3'b111;
    res_full3  = 3'b000;
    #2;
    check("rst_write", write, 0);
    check("rst_read_a", read_a, 0);
    check("rst_busy", busy, 0);
    check("rst_tag", grant_tag, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Lone requester: flux 1 only
    opa_empty = 2'b01;
    opb_empty = 2'b01;
    for (int c = 0; c < 10; c++) begin
      #1;
      check($sformatf("single_w%0d", c), write, exp_w1[c]);
      if (exp_w1[c] == 1) begin
        check($sformatf("single_ra%0d", c), read_a, 2);
        check($sformatf("single_rb%0d", c), read_b, 2);
        check($sformatf("single_t%0d", c), grant_tag, 1);
      end
      tick();
    end
    tick();
    // Reset in the middle of a firing cycle
    #1;
    check("mid_fire_before", write, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_write", write, 0);
    check("mid_rst_read_a", read_a, 0);
    check("mid_rst_read_b", read_b, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tag", grant_tag, 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_busy", busy, 0);
    check("post_rst_tag", grant_tag, 0);

    // Both fluxes ready continuously
    do_reset();
    opa_empty = 2'b00;
    opb_empty = 2'b00;
    wr_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      check($sformatf("both_w%0d", c), write, exp_w2[c]);
      if (exp_w2[c] == 1) begin
        check($sformatf("both_t%0d", c), grant_tag, exp_t2[c]);
        check($sformatf("both_ra%0d", c), read_a, (exp_t2[c] == 1) ? 2 : 1);
      end
      if (c >= 1 && c <= 10 && write) wr_cnt++;
      tick();
    end
`ifdef FLUX_FIXED_PRIO_EN
    check("both_duty", wr_cnt, 10);
`else
    check("both_duty", wr_cnt, 8);
`endif

    // Granted flux 0 hits a full result FIFO after two firings
    do_reset();
    #1; check("nr_w0", write, 0); tick();
    #1; check("nr_w1", write, 1); check("nr_t1", grant_tag, 0); tick();
    #1; check("nr_w2", write, 1); tick();
    res_full = 2'b01;
    #1;
    check("nr_w3", write, 0);
    check("nr_busy3", busy, 1);
    check("nr_ra3", read_a, 0);
    tick();
    res_full = 2'b00;
    #1;
    check("nr_busy4", busy, 0);
    check("nr_w4", write, 0);
    tick();
    #1;
    check("nr_w5", write, 1);
    check("nr_t5", grant_tag, exp_tag_alt);
    check("nr_ra5", read_a, (exp_tag_alt == 1) ? 2 : 1);

    // enable dropped mid-burst
    do_reset();
    #1; check("en_w0", write, 0); tick();
    #1; check("en_w1", write, 1); tick();
    enable = 1'b0;
    #1;
    check("en_w2", write, 0);
    check("en_busy2", busy, 1);
    tick();
    #1;
    check("en_busy3", busy, 0);
    check("en_w3", write, 0);
    tick();
    enable = 1'b1;
    #1; check("en_w4", write, 0); tick();
    #1;
    check("en_w5", write, 1);
    check("en_t5", grant_tag, exp_tag_alt);

    // FLUX=3: flux 2 first, then flux 0 after the pointer wraps
    opa_empty = 2'b11;
    opb_empty = 2'b11;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      opa_empty3 = (c < 3) ? 3'b011 : 3'b110;
      opb_empty3 = opa_empty3;
      #1;
      check($sformatf("f3_w%0d", c), write3, exp_w3[c]);
      check($sformatf("f3_range%0d", c), int'(grant_tag3 < 2'd3), 1);
      if (exp_w3[c] == 1) begin
        check($sformatf("f3_t%0d", c), grant_tag3, (c < 3) ? 2 : 0);
        check($sformatf("f3_ra%0d", c), read_a3, (c < 3) ? 4 : 1);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
